// File: rtl/rf_dual_if.sv
// Bus bundle for the rf_dual register file: write port, two read ports,
// clear request and status, plus the sequencer state exposed for debug.
interface rf_dual_if #(
    parameter int DATA_W = 8,
    parameter int ADR_W  = 3
);
    // ready is a level status, not a per-transfer handshake: while it is low
    // the file is sweeping, ce writes are ignored and reads return zero.
    // A write is accepted on any rising edge with ce=1 and ready=1 (and clr=0);
    // a read address sampled on an edge yields its data after that edge.
    logic              ce;
    logic [ADR_W-1:0]  wr_adr;
    logic [DATA_W-1:0] data_in;
    logic [ADR_W-1:0]  rd_adr_a;
    logic [ADR_W-1:0]  rd_adr_b;
    logic              clr;
    logic [DATA_W-1:0] data_out_a;
    logic [DATA_W-1:0] data_out_b;
    logic              ready;
    logic [0:0]        dbg_state;
    logic [ADR_W-1:0]  dbg_ptr;

    modport master (
        output ce, wr_adr, data_in, rd_adr_a, rd_adr_b, clr,
        input  data_out_a, data_out_b, ready, dbg_state, dbg_ptr
    );

    modport slave (
        input  ce, wr_adr, data_in, rd_adr_a, rd_adr_b, clr,
        output data_out_a, data_out_b, ready, dbg_state, dbg_ptr
    );
endinterface

// File: rtl/rf_dual.sv
// Register file with one write port, two registered read ports with
// write-to-read bypass, and a clear sequencer that zeroes every register.
module rf_dual #(
    parameter int DATA_W   = 8,
    parameter int ADR_W    = 3,
    parameter int ZERO_REG = 0
) (
    input  logic      clk,
    input  logic      rst,
    rf_dual_if.slave  bus
);
    localparam int DEPTH = 2 ** ADR_W;
    localparam logic [ADR_W-1:0] PTR_LAST = ADR_W'(DEPTH - 1);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]        state;
    logic [ADR_W-1:0]  ptr;
    logic              ready_q;
    logic [DATA_W-1:0] out_a_q;
    logic [DATA_W-1:0] out_b_q;
    logic [DATA_W-1:0] regs [DEPTH];

    logic              run;
    logic              wr_drop;
    logic              wr_eff;
    logic [DATA_W-1:0] rd_a_val;
    logic [DATA_W-1:0] rd_b_val;

    // Read mux shared by both ports: stored value, bypassed new data, or
    // the hardwired zero of register 0 (which overrides the bypass).
    function automatic logic [DATA_W-1:0] read_sel(
        input logic [ADR_W-1:0]  adr,
        input logic [DATA_W-1:0] stored,
        input logic              bypass_en,
        input logic [ADR_W-1:0]  bypass_adr,
        input logic [DATA_W-1:0] bypass_data
    );
        logic [DATA_W-1:0] val;
        val = stored;
        if (bypass_en && (bypass_adr == adr)) val = bypass_data;
        if ((ZERO_REG != 0) && (adr == '0)) val = '0;
        return val;
    endfunction

    always_comb begin
        run      = (state == ST_RUN);
        wr_drop  = (ZERO_REG != 0) && (bus.wr_adr == '0);
        wr_eff   = run && bus.ce && !bus.clr && !wr_drop;
        rd_a_val = read_sel(bus.rd_adr_a, regs[bus.rd_adr_a], wr_eff,
                            bus.wr_adr, bus.data_in);
        rd_b_val = read_sel(bus.rd_adr_b, regs[bus.rd_adr_b], wr_eff,
                            bus.wr_adr, bus.data_in);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            ptr     <= '0;
            ready_q <= 1'b0;
            out_a_q <= '0;
            out_b_q <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    ptr     <= ptr + 1'b1;
                    out_a_q <= '0;
                    out_b_q <= '0;
                    if (ptr == PTR_LAST) begin
                        state   <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    out_a_q <= rd_a_val;
                    out_b_q <= rd_b_val;
                    if (bus.clr) begin
                        state   <= ST_CLEAR;
                        ptr     <= '0;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_CLEAR;
                    ptr     <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage carries no reset; the sweep is what brings it to zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR) begin
                regs[ptr] <= '0;
            end else if (wr_eff) begin
                regs[bus.wr_adr] <= bus.data_in;
            end
        end
    end

    assign bus.data_out_a = out_a_q;
    assign bus.data_out_b = out_b_q;
    assign bus.ready      = ready_q;
    assign bus.dbg_state  = state;
    assign bus.dbg_ptr    = ptr;
endmodule

// File: tb/tb_rf_dual.sv
// Directed bench for rf_dual: one instance with ZERO_REG=0, one with ZERO_REG=1.
module tb_rf_dual;
    logic clk;
    logic rst0;
    logic rst1;
    int   n_checks;
    int   n_fail;

    rf_dual_if #(.DATA_W(8), .ADR_W(3)) if0 ();
    rf_dual_if #(.DATA_W(8), .ADR_W(3)) if1 ();

    rf_dual #(.DATA_W(8), .ADR_W(3), .ZERO_REG(0)) u_dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (if0)
    );

    rf_dual #(.DATA_W(8), .ADR_W(3), .ZERO_REG(1)) u_dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (if1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        if0.ce = 1'b0; if0.clr = 1'b0; if0.wr_adr = '0; if0.data_in = '0;
    endtask

    // Reset, sweep timing, all registers read zero.
    task automatic test_reset();
        idle0();
        if0.rd_adr_a = '0; if0.rd_adr_b = '0;
        rst0 = 1'b1;
        step();
        step();
        n_checks++;
        if (if0.ready !== 1'b0 || if0.data_out_a !== 8'h00 || if0.data_out_b !== 8'h00 || if0.dbg_ptr !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b a=%h b=%h ptr=%0d, required 0 00 00 0",
                     if0.ready, if0.data_out_a, if0.data_out_b, if0.dbg_ptr);
        end
        rst0 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            n_checks++;
            if (if0.ready !== (i == 8)) begin
                n_fail++;
                $display("FAIL reset_ready_edge%0d: ready=%b required %b", i, if0.ready, (i == 8));
            end
        end
        n_checks++;
        if (if0.dbg_state !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state_run: state=%b required 1", if0.dbg_state);
        end
        for (int i = 0; i < 8; i++) begin
            if0.rd_adr_a = 3'(i);
            if0.rd_adr_b = 3'(7 - i);
            step();
            n_checks++;
            if (if0.data_out_a !== 8'h00 || if0.data_out_b !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_read%0d: a=%h b=%h required 00 00", i, if0.data_out_a, if0.data_out_b);
            end
        end
    endtask

    // Plain write then read, then same-cycle bypass on both ports.
    task automatic test_write_bypass();
        if0.ce = 1'b1; if0.wr_adr = 3'd2; if0.data_in = 8'h06;
        if0.rd_adr_a = 3'd0;
        step();
        idle0();
        if0.rd_adr_a = 3'd2;
        step();
        n_checks++;
        if (if0.data_out_a !== 8'h06) begin
            n_fail++;
            $display("FAIL write_read: a=%h required 06", if0.data_out_a);
        end
        if0.ce = 1'b1; if0.wr_adr = 3'd2; if0.data_in = 8'h07;
        if0.rd_adr_a = 3'd2; if0.rd_adr_b = 3'd2;
        step();
        idle0();
        n_checks++;
        if (if0.data_out_a !== 8'h07 || if0.data_out_b !== 8'h07) begin
            n_fail++;
            $display("FAIL bypass: a=%h b=%h required 07 07", if0.data_out_a, if0.data_out_b);
        end
    endtask

    // Fill, then clr with a coincident write; clr held early in the sweep.
    task automatic test_clear();
        for (int i = 0; i < 8; i++) begin
            if0.ce = 1'b1; if0.wr_adr = 3'(i); if0.data_in = 8'h10 + 8'(i);
            step();
        end
        idle0();
        if0.rd_adr_a = 3'd5; if0.rd_adr_b = 3'd0;
        step();
        n_checks++;
        if (if0.data_out_a !== 8'h15 || if0.data_out_b !== 8'h10) begin
            n_fail++;
            $display("FAIL fill_read: a=%h b=%h required 15 10", if0.data_out_a, if0.data_out_b);
        end
        if0.clr = 1'b1; if0.ce = 1'b1; if0.wr_adr = 3'd5; if0.data_in = 8'hFF;
        step();
        if0.ce = 1'b0;
        n_checks++;
        if (if0.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_enter: ready=%b required 0", if0.ready);
        end
        for (int i = 1; i <= 8; i++) begin
            if0.clr = (i <= 3);
            step();
            n_checks++;
            if (if0.ready !== (i == 8) || if0.data_out_a !== 8'h00) begin
                n_fail++;
                $display("FAIL clear_edge%0d: ready=%b a=%h required %b 00", i, if0.ready, if0.data_out_a, (i == 8));
            end
        end
        idle0();
        for (int i = 0; i < 8; i++) begin
            if0.rd_adr_a = 3'(i);
            if0.rd_adr_b = 3'(i);
            step();
            n_checks++;
            if (if0.data_out_a !== 8'h00 || if0.data_out_b !== 8'h00) begin
                n_fail++;
                $display("FAIL clear_read%0d: a=%h b=%h required 00 00", i, if0.data_out_a, if0.data_out_b);
            end
        end
    endtask

    // Reset in mid-sweep restarts it; ce writes during the sweep are ignored.
    task automatic test_reset_mid_sweep();
        if0.clr = 1'b1;
        step();
        if0.clr = 1'b0;
        if0.ce = 1'b1; if0.wr_adr = 3'd0; if0.data_in = 8'hEE;
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if (if0.dbg_ptr !== 3'd4) begin
            n_fail++;
            $display("FAIL mid_sweep_ptr: ptr=%0d required 4", if0.dbg_ptr);
        end
        rst0 = 1'b1;
        step();
        rst0 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            n_checks++;
            if (if0.ready !== (i == 8)) begin
                n_fail++;
                $display("FAIL restart_edge%0d: ready=%b required %b", i, if0.ready, (i == 8));
            end
        end
        idle0();
        for (int i = 0; i < 8; i++) begin
            if0.rd_adr_a = 3'(i);
            if0.rd_adr_b = 3'(7 - i);
            step();
            n_checks++;
            if (if0.data_out_a !== 8'h00 || if0.data_out_b !== 8'h00) begin
                n_fail++;
                $display("FAIL restart_read%0d: a=%h b=%h required 00 00", i, if0.data_out_a, if0.data_out_b);
            end
        end
    endtask

    // Register 0 hardwired to zero on the second instance.
    task automatic test_zero_reg();
        rst1 = 1'b1;
        step();
        rst1 = 1'b0;
        for (int i = 0; i < 8; i++) step();
        n_checks++;
        if (if1.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zr_ready: ready=%b required 1", if1.ready);
        end
        if1.ce = 1'b1; if1.wr_adr = 3'd0; if1.data_in = 8'hAA;
        if1.rd_adr_a = 3'd0; if1.rd_adr_b = 3'd0;
        step();
        n_checks++;
        if (if1.data_out_a !== 8'h00 || if1.data_out_b !== 8'h00) begin
            n_fail++;
            $display("FAIL zr_bypass0: a=%h b=%h required 00 00", if1.data_out_a, if1.data_out_b);
        end
        if1.wr_adr = 3'd1; if1.data_in = 8'h55; if1.rd_adr_b = 3'd1;
        step();
        if1.ce = 1'b0;
        n_checks++;
        if (if1.data_out_a !== 8'h00 || if1.data_out_b !== 8'h55) begin
            n_fail++;
            $display("FAIL zr_bypass1: a=%h b=%h required 00 55", if1.data_out_a, if1.data_out_b);
        end
        if1.rd_adr_a = 3'd1; if1.rd_adr_b = 3'd0;
        step();
        n_checks++;
        if (if1.data_out_a !== 8'h55 || if1.data_out_b !== 8'h00) begin
            n_fail++;
            $display("FAIL zr_read: a=%h b=%h required 55 00", if1.data_out_a, if1.data_out_b);
        end
    endtask

    // Consecutive writes with port B reading the previously written address.
    task automatic test_back_to_back();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h00; exp_b[1] = 8'h33; exp_b[2] = 8'h44; exp_b[3] = 8'h55;
        for (int i = 0; i < 4; i++) begin
            if0.ce      = (i < 3);
            if0.wr_adr  = 3'(3 + i);
            if0.data_in = (i < 3) ? 8'h33 + 8'(i * 8'h11) : 8'h00;
            if0.rd_adr_b = 3'(2 + i);
            step();
            n_checks++;
            if (if0.data_out_b !== exp_b[i]) begin
                n_fail++;
                $display("FAIL b2b_trail%0d: b=%h required %h", i, if0.data_out_b, exp_b[i]);
            end
        end
        idle0();
        for (int i = 0; i < 3; i++) begin
            if0.rd_adr_a = 3'(3 + i);
            step();
            n_checks++;
            if (if0.data_out_a !== exp_b[i + 1]) begin
                n_fail++;
                $display("FAIL b2b_readback%0d: a=%h required %h", i, if0.data_out_a, exp_b[i + 1]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst0 = 1'b1;
        rst1 = 1'b1;
        idle0();
        if0.rd_adr_a = '0; if0.rd_adr_b = '0;
        if1.ce = 1'b0; if1.clr = 1'b0; if1.wr_adr = '0; if1.data_in = '0;
        if1.rd_adr_a = '0; if1.rd_adr_b = '0;
        test_reset();
        test_write_bypass();
        test_clear();
        test_reset_mid_sweep();
        test_zero_reg();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_dual.md
Name: rf_dual

Overview:
- Parametrised successor to the 8x8 single-port register file.
- One write port and two independent read ports, for two-operand ALU instructions.
- Registered reads with write-to-read bypass.
- Hardware clear sequencer sweeps every register to zero after reset or on request, and holds `ready` low while it runs.

Parameters:
- DATA_W, 8: register width in bits.
- ADR_W, 3: address width; DEPTH = 2**ADR_W registers.
- ZERO_REG, 0: when 1, register 0 is hardwired to zero (writes dropped, reads return 0).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ce  input  1  write enable; one write per cycle.
- wr_adr  input  ADR_W  write address.
- data_in  input  DATA_W  write data.
- rd_adr_a  input  ADR_W  read port A address.
- rd_adr_b  input  ADR_W  read port B address.
- clr  input  1  clear request; one-cycle pulse or level.
- data_out_a  output  DATA_W  read port A data, registered.
- data_out_b  output  DATA_W  read port B data, registered.
- ready  output  1  high when the file accepts writes and returns valid reads.

Behaviour:
- Decided: one clock (`clk`); reset `rst` is synchronous and active-high.
- States: CLEAR, RUN. Internal sweep pointer `ptr` is ADR_W bits wide.
- Reset: on an edge with rst=1 → state=CLEAR, ptr=0, ready=0, data_out_a=0, data_out_b=0.
  - Register contents are not reset directly; the sweep zeroes them.
- CLEAR state, each edge:
  - reg[ptr] <= 0; ptr <= ptr+1.
  - When ptr==DEPTH-1 → state=RUN, ready=1 at that same edge.
  - ready therefore rises on the DEPTH-th edge after the reset edge (edge 8 for ADR_W=3).
- In CLEAR, ce is ignored (no write) and data_out_a/b are driven to 0 every edge.
- rst during CLEAR restarts the sweep from ptr=0.
- RUN state with clr=1 at an edge:
  - state=CLEAR, ptr=0, ready=0 at that edge.
  - A coincident ce write is dropped; clr has priority.
  - clr held during CLEAR has no effect; the sweep is not restarted.
- RUN write: with ce=1 at an edge, reg[wr_adr] <= data_in.
  - If ZERO_REG=1 and wr_adr==0, the write is dropped.
- RUN read, ports A and B independent and identical:
  - data_out_x <= reg[rd_adr_x] at each edge; 1-cycle latency.
  - Outputs hold the last sampled value until the next edge.
- Bypass: if an effective write (ce=1, RUN, clr=0, not a dropped zero-reg write) targets the read address in the same cycle, data_out_x <= data_in (new data, not old).
- ZERO_REG=1 and rd_adr_x==0 → data_out_x <= 0, regardless of bypass.
- Both ports reading the same address return identical data.
- No arithmetic; all widths exact. Addresses always in range; DEPTH is a power of two.

Test Plan (DATA_W=8, ADR_W=3, ZERO_REG=0 unless noted):
1. Assert rst 2 cycles, then release → ready=0 for 7 edges after the last reset edge, ready=1 after the 8th; data_out_a/b=0; reads of all 8 addresses return 0.
2. After ready=1: ce=1, wr_adr=2, data_in=6 for one cycle; then rd_adr_a=2 → data_out_a=6 one edge after the read address is applied.
   - Then ce=1, wr_adr=2, data_in=7 with rd_adr_a=2 and rd_adr_b=2 in the same cycle → both outputs =7 after that edge (bypass).
3. Fill regs 0..7 with 0x10..0x17; then pulse clr with ce=1, wr_adr=5, data_in=0xFF in the same cycle → ready=0 for 8 edges; afterwards reg5 reads 0 (not 0xFF), all regs read 0.
4. Assert rst mid-sweep (4 edges into CLEAR) → ready stays 0 until 8 edges after the new reset edge; ce writes attempted during CLEAR do not persist.
5. ZERO_REG=1: write 0xAA to addr 0 and 0x55 to addr 1, with rd_adr_a=0 bypass in the write cycle → data_out_a=0 always; addr 1 reads 0x55.
6. Back-to-back writes to addrs 3,4,5 (values 0x33, 0x44, 0x55) while port B trails one address behind → data_out_b shows 0x33, then 0x44 with 1-edge latency; no lost writes.
